// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared types, state encodings and format helpers for the
//               iterative IEEE-754 divider.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int C_MAX_W = 128;

    // FSM encoding
    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_UNPACK = 3'd1;
    localparam logic [2:0] C_ST_DIVIDE = 3'd2;
    localparam logic [2:0] C_ST_ROUND  = 3'd3;
    localparam logic [2:0] C_ST_DONE   = 3'd4;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } op_class_e;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fpu_flags_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [C_MAX_W-1:0] fp_inf(input int exp_w, input int man_w);
        return ((C_MAX_W'(1) << exp_w) - C_MAX_W'(1)) << man_w;
    endfunction

    function automatic logic [C_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (C_MAX_W'(1) << (man_w - 1));
    endfunction

    // Subnormals (exp == 0) are flushed to ZERO regardless of fraction
    function automatic op_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_nz);
        if (exp_zero)     return CLS_ZERO;
        else if (!exp_ones) return CLS_NORM;
        else if (frac_nz) return CLS_NAN;
        else              return CLS_INF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_div_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_div_iter_if
// Description : Operand/result handshake bundle for fpu_div_iter. The flags
//               signal exists only when FPU_DIV_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_div_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;

`ifdef FPU_DIV_FLAGS_EN
    logic [4:0]   flags;

    modport master (output in_valid, op_a, op_b, out_ready,
                    input  in_ready, out_valid, result, flags);
    modport slave  (input  in_valid, op_a, op_b, out_ready,
                    output in_ready, out_valid, result, flags);
`else
    modport master (output in_valid, op_a, op_b, out_ready,
                    input  in_ready, out_valid, result);
    modport slave  (input  in_valid, op_a, op_b, out_ready,
                    output in_ready, out_valid, result);
`endif

endinterface
`default_nettype wire

// File: rtl/fpu_div_mant_core.sv
`default_nettype none
// ============================================================================
// Module      : fpu_div_mant_core
// Description : Restoring mantissa divider, one quotient bit per cycle,
//               producing floor(ma * 2^(MAN_W+3) / mb) and a sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_div_mant_core #(
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAN_W:0]   ma,
    input  logic [MAN_W:0]   mb,
    output logic [MAN_W+3:0] q,
    output logic             rem_nz,
    output logic             done
);
    localparam int QW = MAN_W + 4;
    localparam int RW = MAN_W + 2;
    localparam int CW = $clog2(QW + 1);

    logic [RW-1:0]  r_rem_q, w_rem_d;
    logic [MAN_W:0] r_div_q, w_div_d;
    logic [QW-1:0]  r_q_q,   w_q_d;
    logic [CW-1:0]  r_cnt_q, w_cnt_d;

    logic [RW-1:0]  w_src_rem;
    logic [MAN_W:0] w_src_div;
    logic           w_ge;
    logic [RW-1:0]  w_rem_sub;

    // The start cycle already resolves the first quotient bit from ma/mb
    always_comb begin
        w_src_rem = start ? {1'b0, ma} : r_rem_q;
        w_src_div = start ? mb : r_div_q;
        w_ge      = w_src_rem >= {1'b0, w_src_div};
        w_rem_sub = w_ge ? (w_src_rem - {1'b0, w_src_div}) : w_src_rem;

        w_rem_d = r_rem_q;
        w_div_d = r_div_q;
        w_q_d   = r_q_q;
        w_cnt_d = r_cnt_q;
        if (start || (r_cnt_q != '0)) begin
            w_rem_d = w_rem_sub << 1;
            w_div_d = w_src_div;
            w_q_d   = {(start ? {(QW-1){1'b0}} : r_q_q[QW-2:0]), w_ge};
            w_cnt_d = start ? CW'(QW - 1) : (r_cnt_q - CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem_q <= '0;
            r_div_q <= '0;
            r_q_q   <= '0;
            r_cnt_q <= '0;
        end else begin
            r_rem_q <= w_rem_d;
            r_div_q <= w_div_d;
            r_q_q   <= w_q_d;
            r_cnt_q <= w_cnt_d;
        end
    end

    assign q      = r_q_q;
    assign rem_nz = |r_rem_q;
    assign done   = !start && (r_cnt_q == CW'(1));

endmodule
`default_nettype wire

// File: rtl/fpu_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_div_iter
// Description : Multi-cycle IEEE-754 divider, RNE rounding, FTZ, specials.
//               Exception flags are built only when FPU_DIV_FLAGS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_div_iter
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic           clk,
    input  logic           rst,
    fpu_div_iter_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int QW = MAN_W + 4;
    localparam int EW = EXP_W + 2;

    localparam logic signed [EW-1:0] C_BIAS    = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] C_EXP_TOP = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] C_ONE     = EW'(1);
    localparam logic signed [EW-1:0] C_ZERO    = EW'(0);
    localparam logic [W-1:0]         C_QNAN    = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0]         C_INF_POS = W'(fp_inf(EXP_W, MAN_W));

    logic [2:0]             r_state_q,  w_state_d;
    logic [W-1:0]           r_a_q,      w_a_d;
    logic [W-1:0]           r_b_q,      w_b_d;
    logic [W-1:0]           r_result_q, w_result_d;
    logic                   r_sign_q,   w_sign_d;
    logic signed [EW-1:0]   r_exp_q,    w_exp_d;

    logic                   w_core_start;
    logic                   w_core_done;
    logic                   w_core_rem_nz;
    logic [QW-1:0]          w_core_q;

    // Operand decode
    logic [EXP_W-1:0]       w_exp_a, w_exp_b;
    logic [MAN_W-1:0]       w_frac_a, w_frac_b;
    op_class_e              w_cls_a, w_cls_b;
    logic                   w_sign_res;
    logic                   w_is_invalid, w_is_dbz, w_is_inf_res, w_is_zero_res;
    logic signed [EW-1:0]   w_exp_diff;

    assign w_exp_a    = r_a_q[W-2:MAN_W];
    assign w_exp_b    = r_b_q[W-2:MAN_W];
    assign w_frac_a   = r_a_q[MAN_W-1:0];
    assign w_frac_b   = r_b_q[MAN_W-1:0];
    assign w_cls_a    = fp_classify(w_exp_a == '0, &w_exp_a, |w_frac_a);
    assign w_cls_b    = fp_classify(w_exp_b == '0, &w_exp_b, |w_frac_b);
    assign w_sign_res = r_a_q[W-1] ^ r_b_q[W-1];
    assign w_exp_diff = $signed({2'b00, w_exp_a}) - $signed({2'b00, w_exp_b}) + C_BIAS;

    assign w_is_invalid  = (w_cls_a == CLS_NAN) || (w_cls_b == CLS_NAN)
                        || ((w_cls_a == CLS_ZERO) && (w_cls_b == CLS_ZERO))
                        || ((w_cls_a == CLS_INF)  && (w_cls_b == CLS_INF));
    assign w_is_dbz      = (w_cls_a == CLS_NORM) && (w_cls_b == CLS_ZERO);
    assign w_is_inf_res  = w_is_dbz || (w_cls_a == CLS_INF);
    assign w_is_zero_res = (w_cls_a == CLS_ZERO) || (w_cls_b == CLS_INF);

    // Normalise and round the raw quotient
    logic [QW-1:0]          w_norm;
    logic signed [EW-1:0]   w_exp_n, w_exp_r;
    logic [MAN_W:0]         w_mant;
    logic [MAN_W-1:0]       w_frac_r;
    logic                   w_g, w_s, w_inc, w_carry, w_ovf, w_unf;

    assign w_norm   = w_core_q[QW-1] ? w_core_q : {w_core_q[QW-2:0], 1'b0};
    assign w_exp_n  = w_core_q[QW-1] ? r_exp_q : (r_exp_q - C_ONE);
    assign w_mant   = w_norm[QW-1:3];
    assign w_g      = w_norm[2];
    assign w_s      = (|w_norm[1:0]) || w_core_rem_nz;
    assign w_inc    = w_g && (w_s || w_mant[0]);
    assign w_carry  = w_inc && (&w_mant);
    assign w_frac_r = w_mant[MAN_W-1:0] + MAN_W'(w_inc);
    assign w_exp_r  = w_exp_n + (w_carry ? C_ONE : C_ZERO);
    assign w_ovf    = w_exp_r >= C_EXP_TOP;
    assign w_unf    = w_exp_r <= C_ZERO;

    always_comb begin
        w_state_d    = r_state_q;
        w_a_d        = r_a_q;
        w_b_d        = r_b_q;
        w_result_d   = r_result_q;
        w_sign_d     = r_sign_q;
        w_exp_d      = r_exp_q;
        w_core_start = 1'b0;
        case (r_state_q)
            C_ST_IDLE: begin
                if (bus.in_valid) begin
                    w_a_d     = bus.op_a;
                    w_b_d     = bus.op_b;
                    w_state_d = C_ST_UNPACK;
                end
            end
            C_ST_UNPACK: begin
                w_state_d = C_ST_DONE;
                if (w_is_invalid) begin
                    w_result_d = C_QNAN;
                end else if (w_is_inf_res) begin
                    w_result_d = {w_sign_res, C_INF_POS[W-2:0]};
                end else if (w_is_zero_res) begin
                    w_result_d = {w_sign_res, {(W-1){1'b0}}};
                end else begin
                    w_core_start = 1'b1;
                    w_sign_d     = w_sign_res;
                    w_exp_d      = w_exp_diff;
                    w_state_d    = C_ST_DIVIDE;
                end
            end
            C_ST_DIVIDE: begin
                if (w_core_done) begin
                    w_state_d = C_ST_ROUND;
                end
            end
            C_ST_ROUND: begin
                w_state_d = C_ST_DONE;
                if (w_ovf) begin
                    w_result_d = {r_sign_q, C_INF_POS[W-2:0]};
                end else if (w_unf) begin
                    w_result_d = {r_sign_q, {(W-1){1'b0}}};
                end else begin
                    w_result_d = {r_sign_q, w_exp_r[EXP_W-1:0], w_frac_r};
                end
            end
            C_ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_d = C_ST_IDLE;
                end
            end
            default: begin
                w_state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= C_ST_IDLE;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_result_q <= '0;
            r_sign_q   <= 1'b0;
            r_exp_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_result_q <= w_result_d;
            r_sign_q   <= w_sign_d;
            r_exp_q    <= w_exp_d;
        end
    end

`ifdef FPU_DIV_FLAGS_EN
    fpu_flags_t r_flags_q, w_flags_d;

    always_comb begin
        w_flags_d = r_flags_q;
        if (r_state_q == C_ST_UNPACK) begin
            w_flags_d             = '0;
            w_flags_d.invalid     = w_is_invalid;
            w_flags_d.div_by_zero = w_is_dbz && !w_is_invalid;
        end else if (r_state_q == C_ST_ROUND) begin
            w_flags_d           = '0;
            w_flags_d.overflow  = w_ovf;
            w_flags_d.underflow = w_unf && !w_ovf;
            w_flags_d.inexact   = w_g || w_s || w_ovf || w_unf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags_q <= '0;
        end else begin
            r_flags_q <= w_flags_d;
        end
    end

    assign bus.flags = r_flags_q;
`endif

    fpu_div_mant_core #(.MAN_W(MAN_W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (w_core_start),
        .ma     ({1'b1, w_frac_a}),
        .mb     ({1'b1, w_frac_b}),
        .q      (w_core_q),
        .rem_nz (w_core_rem_nz),
        .done   (w_core_done)
    );

    assign bus.in_ready  = (r_state_q == C_ST_IDLE) && !rst;
    assign bus.out_valid = (r_state_q == C_ST_DONE);
    assign bus.result    = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_div_iter
// Description : Directed self-checking bench for fpu_div_iter in single and
//               double precision; flag checks compile in with FPU_DIV_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_div_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fpu_div_iter_if #(.EXP_W(8),  .MAN_W(23)) bus_s ();
    fpu_div_iter_if #(.EXP_W(11), .MAN_W(52)) bus_d ();

    fpu_div_iter #(.EXP_W(8),  .MAN_W(23)) u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    fpu_div_iter #(.EXP_W(11), .MAN_W(52)) u_dut_d (.clk(clk), .rst(rst), .bus(bus_d));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    // lat counts edges with the accepting edge as edge 1
    task automatic run_s(input logic [31:0] a, input logic [31:0] b, output int lat);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus_s.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        bus_s.in_valid = 1'b1;
        bus_s.op_a     = a;
        bus_s.op_b     = b;
        @(posedge clk); #1;
        bus_s.in_valid = 1'b0;
        bus_s.op_a     = '1;
        bus_s.op_b     = '1;
        lat = 1;
        while (!bus_s.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus_s.out_valid) lat = -1;
    endtask

    task automatic retire_s();
        @(negedge clk);
        bus_s.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_s.out_ready = 1'b0;
    endtask

    task automatic run_d(input logic [63:0] a, input logic [63:0] b, output int lat);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus_d.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        bus_d.in_valid = 1'b1;
        bus_d.op_a     = a;
        bus_d.op_b     = b;
        @(posedge clk); #1;
        bus_d.in_valid = 1'b0;
        lat = 1;
        while (!bus_d.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus_d.out_valid) lat = -1;
    endtask

    task automatic retire_d();
        @(negedge clk);
        bus_d.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_d.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus_s.in_ready, bus_s.out_valid, bus_s.result} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_hold_s: got rdy=%0b vld=%0b res=%h, want 0/0/0",
                     bus_s.in_ready, bus_s.out_valid, bus_s.result);
        end
        n_cmp++;
        if ({bus_d.in_ready, bus_d.out_valid, bus_d.result} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_hold_d: got rdy=%0b vld=%0b res=%h, want 0/0/0",
                     bus_d.in_ready, bus_d.out_valid, bus_d.result);
        end
`ifdef FPU_DIV_FLAGS_EN
        n_cmp++;
        if (bus_s.flags !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", bus_s.flags);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus_s.in_ready, bus_s.out_valid, bus_d.in_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_release: got rdy_s=%0b vld_s=%0b rdy_d=%0b, want 1/0/1",
                     bus_s.in_ready, bus_s.out_valid, bus_d.in_ready);
        end
    endtask

    task automatic test_normal();
        vec_t v [4];
        int   lat;
        v[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29};
        v[1] = '{32'hBFC00000, 32'h3F000000, 32'hC0400000, 5'b00000, 29};
        v[2] = '{32'h3F800000, 32'h3F000000, 32'h40000000, 5'b00000, 29};
        v[3] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29};
        for (int i = 0; i < 4; i++) begin
            run_s(v[i].a, v[i].b, lat);
            n_cmp++;
            if (bus_s.result !== v[i].res) begin
                n_fail++;
                $display("FAIL normal_res[%0d]: got %h want %h", i, bus_s.result, v[i].res);
            end
            n_cmp++;
            if (lat !== v[i].lat) begin
                n_fail++;
                $display("FAIL normal_lat[%0d]: got %0d want %0d", i, lat, v[i].lat);
            end
`ifdef FPU_DIV_FLAGS_EN
            n_cmp++;
            if (bus_s.flags !== v[i].fl) begin
                n_fail++;
                $display("FAIL normal_flags[%0d]: got %b want %b", i, bus_s.flags, v[i].fl);
            end
`endif
            retire_s();
        end
    endtask

    task automatic test_specials();
        vec_t v [6];
        int   lat;
        v[0] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2};
        v[1] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2};
        v[2] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 2};
        v[3] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2};
        v[4] = '{32'h40000000, 32'hFF800000, 32'h80000000, 5'b00000, 2};
        v[5] = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 2};
        for (int i = 0; i < 6; i++) begin
            run_s(v[i].a, v[i].b, lat);
            n_cmp++;
            if (bus_s.result !== v[i].res) begin
                n_fail++;
                $display("FAIL special_res[%0d]: got %h want %h", i, bus_s.result, v[i].res);
            end
            n_cmp++;
            if (lat !== v[i].lat) begin
                n_fail++;
                $display("FAIL special_lat[%0d]: got %0d want %0d", i, lat, v[i].lat);
            end
`ifdef FPU_DIV_FLAGS_EN
            n_cmp++;
            if (bus_s.flags !== v[i].fl) begin
                n_fail++;
                $display("FAIL special_flags[%0d]: got %b want %b", i, bus_s.flags, v[i].fl);
            end
`endif
            retire_s();
        end
    endtask

    task automatic test_overflow_underflow();
        vec_t v [2];
        int   lat;
        v[0] = '{32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 5'b00101, 29};
        v[1] = '{32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 29};
        for (int i = 0; i < 2; i++) begin
            run_s(v[i].a, v[i].b, lat);
            n_cmp++;
            if (bus_s.result !== v[i].res) begin
                n_fail++;
                $display("FAIL range_res[%0d]: got %h want %h", i, bus_s.result, v[i].res);
            end
            n_cmp++;
            if (lat !== v[i].lat) begin
                n_fail++;
                $display("FAIL range_lat[%0d]: got %0d want %0d", i, lat, v[i].lat);
            end
`ifdef FPU_DIV_FLAGS_EN
            n_cmp++;
            if (bus_s.flags !== v[i].fl) begin
                n_fail++;
                $display("FAIL range_flags[%0d]: got %b want %b", i, bus_s.flags, v[i].fl);
            end
`endif
            retire_s();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int seen;
        run_s(32'h40C00000, 32'h40000000, lat);
        @(negedge clk);
        bus_s.in_valid = 1'b1;
        bus_s.op_a     = 32'h3F800000;
        bus_s.op_b     = 32'h40400000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({bus_s.out_valid, bus_s.in_ready, bus_s.result} !== {2'b10, 32'h40400000}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got vld=%0b rdy=%0b res=%h, want 1/0/40400000",
                         i, bus_s.out_valid, bus_s.in_ready, bus_s.result);
            end
        end
        @(negedge clk);
        bus_s.in_valid = 1'b0;
        retire_s();
        n_cmp++;
        if ({bus_s.out_valid, bus_s.in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_release: got vld=%0b rdy=%0b, want 0/1",
                     bus_s.out_valid, bus_s.in_ready);
        end
        seen = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (bus_s.out_valid) seen = 1;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL backpressure_ignored_input: got spurious out_valid=%0d want 0", seen);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        @(negedge clk);
        bus_s.in_valid = 1'b1;
        bus_s.op_a     = 32'h40C00000;
        bus_s.op_b     = 32'h40000000;
        @(posedge clk); #1;
        bus_s.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus_s.out_valid, bus_s.in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_in_reset: got vld=%0b rdy=%0b, want 0/0",
                     bus_s.out_valid, bus_s.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus_s.out_valid, bus_s.in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_after: got vld=%0b rdy=%0b, want 0/1",
                     bus_s.out_valid, bus_s.in_ready);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus_s.out_valid) seen = 1;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_result: got out_valid seen=%0d want 0", seen);
        end
        run_s(32'h3F800000, 32'h40400000, lat);
        n_cmp++;
        if ({bus_s.result, lat} !== {32'h3EAAAAAB, 32'sd29}) begin
            n_fail++;
            $display("FAIL abort_recover: got res=%h lat=%0d want 3EAAAAAB/29", bus_s.result, lat);
        end
        retire_s();
    endtask

    task automatic test_double();
        int lat;
        run_d(64'h4018000000000000, 64'h4000000000000000, lat);
        n_cmp++;
        if (bus_d.result !== 64'h4008000000000000) begin
            n_fail++;
            $display("FAIL double_6_2_res: got %h want 4008000000000000", bus_d.result);
        end
        n_cmp++;
        if (lat !== 58) begin
            n_fail++;
            $display("FAIL double_6_2_lat: got %0d want 58", lat);
        end
        retire_d();
        run_d(64'h3FF0000000000000, 64'h4008000000000000, lat);
        n_cmp++;
        if (bus_d.result !== 64'h3FD5555555555555) begin
            n_fail++;
            $display("FAIL double_1_3_res: got %h want 3FD5555555555555", bus_d.result);
        end
        n_cmp++;
        if (lat !== 58) begin
            n_fail++;
            $display("FAIL double_1_3_lat: got %0d want 58", lat);
        end
`ifdef FPU_DIV_FLAGS_EN
        n_cmp++;
        if (bus_d.flags !== 5'b00001) begin
            n_fail++;
            $display("FAIL double_1_3_flags: got %b want 00001", bus_d.flags);
        end
`endif
        retire_d();
    endtask

    initial begin
        bus_s.in_valid  = 1'b0;
        bus_s.op_a      = '0;
        bus_s.op_b      = '0;
        bus_s.out_ready = 1'b0;
        bus_d.in_valid  = 1'b0;
        bus_d.op_a      = '0;
        bus_d.op_b      = '0;
        bus_d.out_ready = 1'b0;

        test_reset();
        test_normal();
        test_specials();
        test_overflow_underflow();
        test_backpressure();
        test_reset_abort();
        test_double();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fpu_div_iter.md
# fpu_div_iter

Parametrised multi-cycle IEEE-754 floating-point divider with valid/ready handshakes on both sides, round-to-nearest-even, full special-operand handling and exception flags. It is the next-generation divider in the FPU datapath, replacing the fixed single-precision divider. It sits beside the adder and multiplier and is driven by the FPU issue logic.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa (fraction) width; word width is W = 1+EXP_W+MAN_W
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  divider idle, can accept
- op_a  in  W  dividend
- op_b  in  W  divisor
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- result  out  W  quotient a/b
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}; present only with FPU_DIV_FLAGS_EN

## Operation
- FSM: IDLE → UNPACK → DIVIDE → ROUND → DONE → IDLE; specials take UNPACK → DONE directly.
- IDLE: in_ready=1. in_valid&&in_ready captures op_a/op_b, enters UNPACK.
- UNPACK: classify each operand as ZERO, NORM, INF or NAN. Subnormal inputs are flushed to ZERO.
- Special results, with sign = sign_a^sign_b except NaN:
  - any NAN, 0/0 or inf/inf → canonical qNaN: sign 0, exp all ones, fraction MSB 1, invalid.
  - NORM/0 → inf, div_by_zero.
  - inf/NORM, inf/0 → inf.
  - 0/NORM, 0/inf, NORM/inf → zero.
- DIVIDE: restoring division on hidden-1 mantissas ma, mb (MAN_W+1 bits). Produces one quotient bit per cycle for MAN_W+4 cycles, giving Q = floor(ma·2^(MAN_W+3)/mb), with a nonzero-remainder flag.
- Biased exponent is E = ea − eb + BIAS, with BIAS = 2^(EXP_W−1)−1, computed signed with EXP_W+2 bits.
- ROUND:
  - If Q MSB = 0: shift Q left 1 and E−=1.
  - Top MAN_W+1 bits form the mantissa, next bit is G, S = OR(remaining bits, remainder≠0).
  - Increment when G&&(S||lsb). Mantissa carry-out → fraction 0, E+=1.
  - inexact = G||S.
- Overflow: E ≥ 2^EXP_W−1 → signed inf, overflow+inexact.
- Underflow: E ≤ 0 → signed zero (FTZ), underflow+inexact.
- DONE: out_valid=1. result/flags stay stable until out_ready, then return to IDLE. in_ready=0 in every state but IDLE; there is no overlap.

## Timing
- Reset: state IDLE, out_valid 0, result 0, flags 0. in_ready is 0 while rst is high and 1 on the first cycle after.
- Normal latency: out_valid is high MAN_W+6 edges after the accepting edge (29 for defaults).
- Special latency: 2 edges.
- Throughput: one operation per latency+1 cycles when out_ready is held high. The DONE→IDLE cycle is not bypassed.
- out_valid&&out_ready in DONE: out_valid drops on the next edge.
- rst mid-operation (any state) aborts on that edge. No result is emitted and the captured operands are discarded.
- Input changes outside the accept edge have no effect.

## Configuration
- FPU_DIV_FLAGS_EN defined: flags port and flag registers exist, set per Operation, valid alongside out_valid.
- FPU_DIV_FLAGS_EN undefined: port and registers are removed. result behaviour is identical.

## Structure
- Package fpu_pkg holds:
  - state enum
  - operand class enum {ZERO, NORM, INF, NAN}
  - flag struct and canonical-NaN/inf constant functions parametrised by EXP_W/MAN_W
  - BIAS function
- Sub-module fpu_div_mant_core is the iterative restoring mantissa divider:
  - inputs: start, ma, mb
  - outputs: q, rem_nz, done
  - stepped one bit per cycle, parametrised by MAN_W

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → 0x40400000, flags 0, out_valid 29 edges after accept. Also 0xBFC00000 / 0x3F000000 → 0xC0400000.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB, inexact only (RNE round-up).
- 0x3F800000 / 0x00000000 → 0x7F800000, div_by_zero. 0/0 → 0x7FC00000, invalid. 0x7FC00001 / 1.0 → 0x7FC00000, invalid. All at 2-edge latency.
- 0x7F7FFFFF / 0x3E800000 → 0x7F800000, overflow+inexact. 0x00800000 / 0x40000000 → 0x00000000, underflow+inexact.
- Backpressure: out_ready low for 10 cycles in DONE → result/out_valid stable, in_ready 0, new in_valid ignored.
- Reset at DIVIDE cycle 5 → out_valid 0, in_ready 1 the next cycle, no result later.
- Repeat cases 1–2 with EXP_W=11, MAN_W=52 and FPU_DIV_FLAGS_EN undefined: 6/2 → 0x4008000000000000 at latency 58.
